memory_to_axis: RTL and testbench

- AXI-Stream master that reads a contiguous block of words from a single-port-read BRAM and streams them out. It is the transmit-side counterpart of the heap-memory AXIS write path.
- Used to return heap or framebuffer contents to the host DMA.
- Command interface: base word address plus length, a start pulse, then busy/done status.
- Sustains one beat per cycle under full tready and tolerates arbitrary backpressure.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_fifo_small.sv | 71 +++++++
 rtl/memory_to_axis.sv | 206 ++++++++++++++++++++
 tb/tb_memory_to_axis.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// axis_pkg: shared types and constants for the memory-to-AXI-Stream read path.
//   m2a_state_t  : control FSM states (IDLE, RUN, DRAIN, FINISH)
//   AXIS_DATA_W  : stream data width (32)
//   AXIS_KEEP_W  : stream keep width (1)
//   cnt_width()  : width of a counter able to hold 0..depth
package axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } m2a_state_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/axis_fifo_small.sv
// axis_fifo_small: small synchronous register FIFO (first-word-fall-through).
//   clk, reset        : clock, synchronous active-high reset (clears storage)
//   push, push_data   : write strobe and data; a push on a full FIFO is taken
//                       only when a pop happens in the same cycle
//   pop, pop_data     : read strobe and current head word
//   full, empty, count: occupancy status
module axis_fifo_small
  import axis_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign count    = count_reg;
  assign do_pop   = pop && !empty;
  // Full-and-popping is fine: the slot being read this cycle is the one written.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_reg[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (reset) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/memory_to_axis.sv
// memory_to_axis: reads length words from a BRAM starting at base_addr and
// streams them out as an AXI-Stream master.
//   clk, reset            : clock, synchronous active-high reset
//   start/base_addr/length: command (sampled in IDLE only); length 0 is legal
//   busy, done            : status; done is a one-cycle completion pulse
//   mem_addr/mem_rd_en    : read port, data returns RD_LATENCY cycles later
//   mem_rd_data           : read data
//   m_axis_*              : stream output (tkeep is constant all-ones)
// Optional: define MEMORY_TO_AXIS_TUSER_SOF_EN to add m_axis_tuser, which
// flags the first beat of each transfer.
module memory_to_axis
  import axis_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int LEN_W      = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [LEN_W-1:0]       length,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd_en,
  input  logic [AXIS_DATA_W-1:0] mem_rd_data,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast,
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
  output logic                   m_axis_tuser,
`endif
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int FIFO_DEPTH = RD_LATENCY + 1;
  localparam int CNT_W      = cnt_width(FIFO_DEPTH);
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
  localparam int FIFO_W     = AXIS_DATA_W + 2;
`else
  localparam int FIFO_W     = AXIS_DATA_W + 1;
`endif

  m2a_state_t        state_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W-1:0]  words_left_reg;
  logic [CNT_W-1:0]  in_flight_reg;

  logic              vld_pipe_reg  [RD_LATENCY];
  logic              last_pipe_reg [RD_LATENCY];

  logic              rd_issue;
  logic              fire;
  logic [CNT_W:0]    credit_used;
  logic              fifo_push;
  logic [FIFO_W-1:0] fifo_push_data;
  logic [FIFO_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic [CNT_W-1:0]  fifo_count;

`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
  logic              first_reg;
  logic              sof_pipe_reg [RD_LATENCY];
`endif

  assign fire = m_axis_tvalid && m_axis_tready;

  // Credits: every issued read must already own a FIFO slot. A pop this cycle
  // frees one, which is what lets the loop sustain one beat per cycle.
  assign credit_used = (CNT_W+1)'(in_flight_reg) + (CNT_W+1)'(fifo_count)
                     - (CNT_W+1)'(fire);
  assign rd_issue = (state_reg == RUN) && (words_left_reg != '0)
                 && (credit_used < (CNT_W+1)'(FIFO_DEPTH));

  assign mem_rd_en = rd_issue;
  assign mem_addr  = addr_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  // Delay line tagging which cycles carry returning read data.
  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_rd_pipe
      logic vld_in;
      logic last_in;
      if (gi == 0) begin : g_head
        assign vld_in  = rd_issue;
        assign last_in = rd_issue && (words_left_reg == LEN_W'(1));
      end else begin : g_tail
        assign vld_in  = vld_pipe_reg[gi-1];
        assign last_in = last_pipe_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_pipe_reg[gi]  <= 1'b0;
          last_pipe_reg[gi] <= 1'b0;
        end else begin
          vld_pipe_reg[gi]  <= vld_in;
          last_pipe_reg[gi] <= last_in;
        end
      end
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
      logic sof_in;
      if (gi == 0) begin : g_sof_head
        assign sof_in = rd_issue && first_reg;
      end else begin : g_sof_tail
        assign sof_in = sof_pipe_reg[gi-1];
      end
      always_ff @(posedge clk) begin
        if (reset) sof_pipe_reg[gi] <= 1'b0;
        else       sof_pipe_reg[gi] <= sof_in;
      end
`endif
    end
  endgenerate

  assign fifo_push = vld_pipe_reg[RD_LATENCY-1];
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
  assign fifo_push_data = {sof_pipe_reg[RD_LATENCY-1], last_pipe_reg[RD_LATENCY-1], mem_rd_data};
  assign m_axis_tuser   = fifo_head[AXIS_DATA_W+1];
`else
  assign fifo_push_data = {last_pipe_reg[RD_LATENCY-1], mem_rd_data};
`endif

  axis_fifo_small #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fire),
    .pop_data  (fifo_head),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_head[AXIS_DATA_W-1:0];
  assign m_axis_tlast  = fifo_head[AXIS_DATA_W];
  assign m_axis_tkeep  = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      addr_reg       <= '0;
      words_left_reg <= '0;
      in_flight_reg  <= '0;
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
      first_reg      <= 1'b0;
`endif
    end else begin
      done_reg      <= 1'b0;
      in_flight_reg <= in_flight_reg + CNT_W'(rd_issue) - CNT_W'(fifo_push);
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg       <= base_addr;
            words_left_reg <= length;
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
            first_reg      <= 1'b1;
`endif
            if (length != '0) begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= FINISH;
              done_reg  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_issue) begin
            addr_reg       <= addr_reg + ADDR_W'(1);
            words_left_reg <= words_left_reg - LEN_W'(1);
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
            first_reg      <= 1'b0;
`endif
            if (words_left_reg == LEN_W'(1)) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (fire && m_axis_tlast) begin
            state_reg <= FINISH;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        FINISH: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_to_axis.sv
// tb_memory_to_axis: scoreboard bench for memory_to_axis. A behavioural BRAM
// returns word (0xA000 + address) after RD_LAT cycles; expected beats and
// read addresses are queued at command time and popped as the DUT produces them.
module tb_memory_to_axis #(
  parameter int RD_LAT = 1
);

  localparam int ADDR_W = 11;
  localparam int LEN_W  = 12;
  localparam int DEPTH  = RD_LAT + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  length = '0;
  logic              busy, done, mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic [31:0]       m_axis_tdata;
  logic [0:0]        m_axis_tkeep;
  logic              m_axis_tlast, m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
  logic              m_axis_tuser;
`endif

  memory_to_axis #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .RD_LATENCY(RD_LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .mem_addr      (mem_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_data   (mem_rd_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        sof;
  } beat_t;

  beat_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  int checks_total  = 0;
  int checks_passed = 0;
  int cyc = 0;
  int ready_mode = 0;
  int rcnt = 0;
  int beats = 0;
  int start_cyc = 0;
  int first_rd_cyc = -1;
  int first_vld_cyc = -1;
  int last_hs_cyc = -1;
  int prev_beat_cyc = -1;
  int outstanding = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural BRAM with RD_LAT-cycle registered read.
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= 32'hA000 + 32'(mem_addr);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[RD_LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  // tready: continuous, or the repeating 1,0,0 pattern.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) m_axis_tready = 1'b1;
    else begin
      m_axis_tready = (rcnt % 3 == 0);
      rcnt++;
    end
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check("stall_data", m_axis_tdata, prev_data);
        check("stall_last", 32'(m_axis_tlast), 32'(prev_last));
      end
      if (mem_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        check("credit", 32'((outstanding - int'(m_axis_tvalid && m_axis_tready)) < DEPTH), 32'd1);
        check("read_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) check("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("tdata", m_axis_tdata, b.data);
          check("tlast", 32'(m_axis_tlast), 32'(b.last));
`ifdef MEMORY_TO_AXIS_TUSER_SOF_EN
          check("tuser", 32'(m_axis_tuser), 32'(b.sof));
`endif
          if (ready_mode == 0 && prev_beat_cyc >= 0)
            check("no_bubble", 32'(cyc), 32'(prev_beat_cyc + 1));
          prev_beat_cyc = cyc;
          if (m_axis_tlast) last_hs_cyc = cyc;
          beats++;
        end
      end
      outstanding += int'(mem_rd_en) - int'(m_axis_tvalid && m_axis_tready);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic start_xfer(input logic [ADDR_W-1:0] base, input int len);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = LEN_W'(len);
    start_cyc = cyc; first_rd_cyc = -1; first_vld_cyc = -1;
    prev_beat_cyc = -1; last_hs_cyc = -1; beats = 0;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      logic [ADDR_W-1:0] a;
      a = base + ADDR_W'(i);
      b.data = 32'hA000 + 32'(a);
      b.last = (i == len - 1);
      b.sof  = (i == 0);
      exp_q.push_back(b);
      addr_q.push_back(a);
    end
    $display("xfer base=0x%0h len=%0d ready_mode=%0d", base, len, ready_mode);
    @(posedge clk); #1;
    start = 1'b0;
    if (len != 0) check("busy_after_start", 32'(busy), 32'd1);
    else          check("zero_len_done", 32'(done), 32'd1);
  endtask

  task automatic wait_done(input string tag, output int dcyc);
    dcyc = -1;
    for (int n = 0; n < 400; n++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, 32'(dcyc >= 0), 32'd1);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dcyc;
    int extra_done;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    reset = 1'b0;

    // Basic transfer with latency checks.
    start_xfer(11'h010, 4);
    wait_done("basic", dcyc);
    check("basic_first_rd_cyc", 32'(first_rd_cyc), 32'(start_cyc + 1));
    check("basic_first_vld_cyc", 32'(first_vld_cyc), 32'(start_cyc + 2 + RD_LAT));
    check("basic_done_cyc", 32'(dcyc), 32'(last_hs_cyc + 1));
    check("basic_beats", 32'(beats), 32'd4);

    // Backpressure 1,0,0,...
    ready_mode = 1; rcnt = 0;
    start_xfer(11'h100, 8);
    wait_done("bp", dcyc);
    check("bp_beats", 32'(beats), 32'd8);
    ready_mode = 0;

    // Address wrap.
    start_xfer(11'h7FE, 4);
    wait_done("wrap", dcyc);
    check("wrap_beats", 32'(beats), 32'd4);

    // Zero length.
    start_xfer(11'h005, 0);
    wait_done("zero", dcyc);
    check("zero_done_cyc", 32'(dcyc), 32'(start_cyc + 1));
    repeat (3) @(posedge clk);
    #1;
    check("zero_no_valid", 32'(first_vld_cyc), 32'hFFFF_FFFF);
    check("zero_beats", 32'(beats), 32'd0);

    // Start while busy is ignored.
    start_xfer(11'h200, 6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 11'h300; length = 12'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ignore", dcyc);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("ignore_single_done", 32'(extra_done), 32'd0);
    check("ignore_beats", 32'(beats), 32'd6);

    // Reset during the third beat.
    start_xfer(11'h040, 10);
    for (int n = 0; n < 100 && beats < 2; n++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_reached", 32'(beats >= 2), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    addr_q.delete();
    reset = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) extra_done++;
      @(posedge clk); #1;
    end
    check("rst_mid_no_done", 32'(extra_done), 32'd0);
    start_xfer(11'h050, 2);
    wait_done("after_rst", dcyc);
    check("after_rst_beats", 32'(beats), 32'd2);

    // Long burst at full rate.
    start_xfer(11'h3F8, 16);
    wait_done("long", dcyc);
    check("long_beats", 32'(beats), 32'd16);
    check("long_first_vld_cyc", 32'(first_vld_cyc), 32'(start_cyc + 2 + RD_LAT));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
